second_phase_stage_scheduler: RTL and testbench
===============================================

SECOND_PHASE_STAGE_SCHEDULER -- requirements
Module: second_phase_stage_scheduler

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 8: number of second-phase stage databases sequenced.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: width of the watchdog counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4095: maximum cycles a stage may run before abort.
REQ-004 SHALL have port clk_fpga, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_fpga, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_start, input, 1: one-cycle request to evaluate the current window.
REQ-007 SHALL have port i_end_count_database, input, NUM_STAGES: per-stage "database fully read" flags.
REQ-008 SHALL have port i_stage_result_valid, input, 1: the stage accumulator verdict is valid.
REQ-009 SHALL have port i_stage_pass, input, 1: verdict, 1 = stage sum reached its threshold.
REQ-010 SHALL have port o_enable, output, NUM_STAGES: one-hot enable to the stage databases.
REQ-011 SHALL have port o_stage_index, output, 3 (clog2 NUM_STAGES): index of the active stage.
REQ-012 SHALL have port o_busy, output, 1: a window evaluation is in progress.
REQ-013 SHALL have port o_done, output, 1: one-cycle pulse at the end of each evaluation.
REQ-014 SHALL have port o_face_detected, output, 1: final verdict; valid while o_done = 1 and held until the next i_start.
REQ-015 SHALL have port o_reject_stage, output, 3: index of the stage that rejected the window or timed out.
REQ-016 SHALL have port o_timeout, output, 1: the last evaluation was aborted by the watchdog.

Function
REQ-017 SHALL implement the states IDLE, RUN, EVAL and DONE.
REQ-018 IDLE: on i_start = 1, SHALL clear stage index, watchdog, o_face_detected and o_timeout, then go to RUN next cycle.
REQ-019 RUN: o_enable SHALL equal 1 << stage index (exactly one bit set); all other states SHALL drive o_enable = 0.
REQ-020 RUN: SHALL go to EVAL on i_end_count_database[stage index] = 1; end_count bits of other stages SHALL be ignored.
REQ-021 RUN: the watchdog SHALL increment every cycle; on reaching TIMEOUT_CYCLES-1 without end_count it SHALL go to DONE with o_timeout = 1, o_face_detected = 0 and o_reject_stage = stage index.
REQ-022 EVAL: SHALL wait for i_stage_result_valid; the watchdog SHALL continue, and a timeout SHALL behave as in RUN.
REQ-023 EVAL with pass and stage index < NUM_STAGES-1: SHALL increment the stage index, clear the watchdog and return to RUN.
REQ-024 EVAL with pass at the last stage: SHALL go to DONE with o_face_detected = 1.
REQ-025 EVAL with fail: SHALL go to DONE with o_face_detected = 0 and o_reject_stage = stage index.
REQ-026 DONE: SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-027 o_busy SHALL be 1 in RUN, EVAL and DONE, and 0 in IDLE.
REQ-028 i_start while not in IDLE SHALL be ignored; no queuing.
REQ-029 i_stage_result_valid in RUN or IDLE SHALL be ignored.
REQ-030 i_end_count and verdict in the same cycle in RUN: only the RUN to EVAL transition occurs; the verdict SHALL be sampled in EVAL.
REQ-031 The watchdog SHALL saturate and never wrap; TIMEOUT_CYCLES SHALL fit in ADDR_WIDTH.
REQ-032 All outputs SHALL be registered, with state changes taking effect on the clock edge after the qualifying input.

Reset
REQ-033 reset_fpga = 0 SHALL asynchronously force IDLE and drive all outputs and counters to 0, including during RUN or EVAL.
REQ-034 After reset deassertion, the block SHALL accept i_start on the first clock edge.

Verification
REQ-035 All pass: i_start, then each stage's end_count after 10 cycles with pass = 1 -> o_enable steps 0x01..0x80; o_done pulse with o_face_detected = 1.
REQ-036 Early reject: stage 2 verdict pass = 0 -> o_done with o_face_detected = 0, o_reject_stage = 2; o_enable never reaches 0x08.
REQ-037 Timeout: TIMEOUT_CYCLES = 16, no end_count -> o_done 16 cycles after RUN entry with o_timeout = 1 and o_reject_stage = 0.
REQ-038 Protocol: i_start pulsed during RUN, and end_count of a non-active stage -> no effect on state or o_enable.
REQ-039 Reset: reset_fpga low during EVAL of stage 5 -> all outputs 0 immediately; a new i_start restarts at stage 0.

Source files
------------

// File: rtl/second_phase_stage_scheduler.sv
// second_phase_stage_scheduler: sequences the second-phase stage databases for one window and reports the verdict
module second_phase_stage_scheduler #(
  parameter int NUM_STAGES     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 4095,
  localparam int IW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  i_start,
  input  logic [NUM_STAGES-1:0] i_end_count_database,
  input  logic                  i_stage_result_valid,
  input  logic                  i_stage_pass,
  output logic [NUM_STAGES-1:0] o_enable,
  output logic [IW-1:0]         o_stage_index,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_face_detected,
  output logic [IW-1:0]         o_reject_stage,
  output logic                  o_timeout
);
  typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] wd, wd_d, wd_inc;
  logic [IW-1:0] idx_d, rej_d;
  logic face_d, tmo_d, last_wd, last_stage;
  assign last_wd    = wd == ADDR_WIDTH'(TIMEOUT_CYCLES - 1);
  assign last_stage = o_stage_index == IW'(NUM_STAGES - 1);
  assign wd_inc     = last_wd ? wd : wd + 1'b1;
  // next-state logic; the watchdog saturates at its limit so it can never wrap
  always_comb begin
    state_d = state;
    idx_d   = o_stage_index;
    wd_d    = wd;
    face_d  = o_face_detected;
    tmo_d   = o_timeout;
    rej_d   = o_reject_stage;
    case (state)
      IDLE: if (i_start) begin
        state_d = RUN;
        idx_d   = '0;
        wd_d    = '0;
        face_d  = 1'b0;
        tmo_d   = 1'b0;
        rej_d   = '0;
      end
      RUN: begin
        wd_d = wd_inc;
        if (i_end_count_database[o_stage_index]) state_d = EVAL;
        else if (last_wd) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          face_d  = 1'b0;
          rej_d   = o_stage_index;
        end
      end
      EVAL: begin
        wd_d = wd_inc;
        if (i_stage_result_valid) begin
          if (!i_stage_pass) begin
            state_d = DONE;
            face_d  = 1'b0;
            rej_d   = o_stage_index;
          end else if (last_stage) begin
            state_d = DONE;
            face_d  = 1'b1;
          end else begin
            state_d = RUN;
            idx_d   = o_stage_index + 1'b1;
            wd_d    = '0;
          end
        end else if (last_wd) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          face_d  = 1'b0;
          rej_d   = o_stage_index;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // every output is registered from the next-state values
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state           <= IDLE;
      wd              <= '0;
      o_stage_index   <= '0;
      o_enable        <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_face_detected <= 1'b0;
      o_reject_stage  <= '0;
      o_timeout       <= 1'b0;
    end else begin
      state           <= state_d;
      wd              <= wd_d;
      o_stage_index   <= idx_d;
      o_enable        <= (state_d == RUN) ? NUM_STAGES'(1) << idx_d : '0;
      o_busy          <= state_d != IDLE;
      o_done          <= state_d == DONE;
      o_face_detected <= face_d;
      o_reject_stage  <= rej_d;
      o_timeout       <= tmo_d;
    end
  end
endmodule

// File: tb/tb_second_phase_stage_scheduler.sv
// tb_second_phase_stage_scheduler: directed checks of stage sequencing, reject, timeout, protocol and reset
module tb_second_phase_stage_scheduler;
  logic clk_fpga = 1'b0;
  logic reset_fpga = 1'b0;
  logic i_start = 1'b0;
  logic [7:0] i_end_count_database = '0;
  logic i_stage_result_valid = 1'b0;
  logic i_stage_pass = 1'b0;
  logic [7:0] o_enable;
  logic [2:0] o_stage_index, o_reject_stage;
  logic o_busy, o_done, o_face_detected, o_timeout;
  int n_cmp = 0;
  int n_bad = 0;

  second_phase_stage_scheduler #(.NUM_STAGES(8), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
    .clk_fpga(clk_fpga),
    .reset_fpga(reset_fpga),
    .i_start(i_start),
    .i_end_count_database(i_end_count_database),
    .i_stage_result_valid(i_stage_result_valid),
    .i_stage_pass(i_stage_pass),
    .o_enable(o_enable),
    .o_stage_index(o_stage_index),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_face_detected(o_face_detected),
    .o_reject_stage(o_reject_stage),
    .o_timeout(o_timeout)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pass_stage(input int s);
    i_end_count_database = 8'(1) << s;
    tick();
    i_end_count_database = '0;
    i_stage_result_valid = 1'b1;
    i_stage_pass = 1'b1;
    tick();
    i_stage_result_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_enable", 32'(o_enable), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    tick();
    reset_fpga = 1'b1;
    // all stages pass
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_enable", 32'(o_enable), 1);
    chk("start_busy", 32'(o_busy), 1);
    for (int s = 0; s < 8; s++) begin
      repeat (9) tick();
      chk("run_enable", 32'(o_enable), 32'(1) << s);
      chk("run_index", 32'(o_stage_index), s);
      i_end_count_database = 8'(1) << s;
      tick();
      i_end_count_database = '0;
      chk("eval_enable", 32'(o_enable), 0);
      i_stage_result_valid = 1'b1;
      i_stage_pass = 1'b1;
      tick();
      i_stage_result_valid = 1'b0;
      if (s < 7) chk("next_enable", 32'(o_enable), 32'(1) << (s + 1));
    end
    chk("all_done", 32'(o_done), 1);
    chk("all_face", 32'(o_face_detected), 1);
    chk("all_timeout", 32'(o_timeout), 0);
    tick();
    chk("all_done_pulse", 32'(o_done), 0);
    chk("all_idle_busy", 32'(o_busy), 0);
    chk("all_face_held", 32'(o_face_detected), 1);
    // early reject at stage 2
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("rej_face_clr", 32'(o_face_detected), 0);
    pass_stage(0);
    pass_stage(1);
    chk("rej_enable2", 32'(o_enable), 32'h04);
    i_end_count_database = 8'h04;
    tick();
    i_end_count_database = '0;
    i_stage_result_valid = 1'b1;
    i_stage_pass = 1'b0;
    tick();
    i_stage_result_valid = 1'b0;
    chk("rej_done", 32'(o_done), 1);
    chk("rej_face", 32'(o_face_detected), 0);
    chk("rej_stage", 32'(o_reject_stage), 2);
    chk("rej_enable", 32'(o_enable), 0);
    chk("rej_timeout", 32'(o_timeout), 0);
    tick();
    // watchdog timeout with no end_count
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", 32'(o_done), 0);
    chk("to_still_run", 32'(o_enable), 1);
    tick();
    chk("to_done", 32'(o_done), 1);
    chk("to_flag", 32'(o_timeout), 1);
    chk("to_reject", 32'(o_reject_stage), 0);
    chk("to_face", 32'(o_face_detected), 0);
    tick();
    // protocol: stray start, foreign end_count, verdict in RUN
    i_start = 1'b1;
    tick();
    chk("pr_enable0", 32'(o_enable), 1);
    tick();
    i_start = 1'b0;
    chk("pr_restart_ign", 32'(o_enable), 1);
    chk("pr_timeout_clr", 32'(o_timeout), 0);
    i_end_count_database = 8'hFE;
    i_stage_result_valid = 1'b1;
    i_stage_pass = 1'b1;
    tick();
    chk("pr_foreign_ign", 32'(o_enable), 1);
    chk("pr_index", 32'(o_stage_index), 0);
    i_end_count_database = 8'h01;
    tick();
    i_end_count_database = '0;
    chk("pr_eval_enable", 32'(o_enable), 0);
    chk("pr_eval_index", 32'(o_stage_index), 0);
    tick();
    i_stage_result_valid = 1'b0;
    chk("pr_next", 32'(o_enable), 2);
    // reset during EVAL of stage 5
    for (int s = 1; s < 5; s++) pass_stage(s);
    i_end_count_database = 8'h20;
    tick();
    i_end_count_database = '0;
    chk("rs_eval_index", 32'(o_stage_index), 5);
    #2;
    reset_fpga = 1'b0;
    #1;
    chk("rs_enable", 32'(o_enable), 0);
    chk("rs_index", 32'(o_stage_index), 0);
    chk("rs_busy", 32'(o_busy), 0);
    chk("rs_misc", 32'({o_done, o_face_detected, o_timeout, o_reject_stage}), 0);
    tick();
    reset_fpga = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("rs_restart", 32'(o_enable), 1);
    chk("rs_restart_idx", 32'(o_stage_index), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
